// File: rtl/eei_pkg.sv
// ---------------------------------------------------------------------------
// eei_pkg
// Shared types and constants for the EEI unit dispatcher:
//   - eei_disp_state_e : dispatcher FSM states (IDLE, WAIT, RESP)
//   - RD_NONE/RD_SINGLE/RD_BATCH/RD_EXTBATCH : rd_op encodings
//   - eei_rsp_t        : captured response fields {error, rd_op, rd_len}
//   - EEI_RD_W         : width of one rd result word
//   - eei_sanitize_len : write-back count cleanup applied on capture
// ---------------------------------------------------------------------------
package eei_pkg;

    localparam int EEI_RD_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } eei_disp_state_e;

    localparam logic [1:0] RD_NONE     = 2'd0;
    localparam logic [1:0] RD_SINGLE   = 2'd1;
    localparam logic [1:0] RD_BATCH    = 2'd2;
    localparam logic [1:0] RD_EXTBATCH = 2'd3;

    typedef struct packed {
        logic       error;
        logic [1:0] rd_op;
        logic [4:0] rd_len;
    } eei_rsp_t;

    // A response that writes nothing back reports a zero count; otherwise the
    // count can never exceed the number of result words the port carries.
    function automatic logic [4:0] eei_sanitize_len(input logic [1:0] rd_op,
                                                    input logic [4:0] rd_len,
                                                    input logic [4:0] rd_max);
        logic [4:0] len_s;
        if (rd_op == RD_NONE) begin
            len_s = 5'd0;
        end else if (rd_len > rd_max) begin
            len_s = rd_max;
        end else begin
            len_s = rd_len;
        end
        return len_s;
    endfunction

endpackage

// File: rtl/eei_unit_decode.sv
// ---------------------------------------------------------------------------
// eei_unit_decode
// Combinational funct3/ext decoder: maps an EEI request onto one of NUM_UNIT
// custom units (unit i serves funct3 == F3_BASE + i).
// Ports:
//   eei_funct3 in  3  unit select field of the request
//   eei_ext    in  1  enhanced (batch) request flag
//   hit        out 1  request maps onto an attached unit that accepts it
//   sel        out 3  index of that unit (meaningful only with hit)
// ---------------------------------------------------------------------------
module eei_unit_decode
    import eei_pkg::*;
#(
    parameter int         NUM_UNIT      = 2,
    parameter int         F3_BASE       = 0,
    parameter logic [7:0] EXT_ONLY_MASK = 8'b0000_0010
) (
    input  logic [2:0] eei_funct3,
    input  logic       eei_ext,
    output logic       hit,
    output logic [2:0] sel
);

    logic [3:0] off_s;
    logic       ext_only_s;

    // Offset from the base opcode; a funct3 below F3_BASE wraps to 9..15 in
    // four bits, so the single range compare also rejects it.
    always_comb begin
        off_s      = {1'b0, eei_funct3} - 4'(F3_BASE);
        ext_only_s = EXT_ONLY_MASK[off_s[2:0]];
        hit        = (off_s < 4'(NUM_UNIT)) && (!ext_only_s || eei_ext);
        sel        = off_s[2:0];
    end

endmodule

// File: rtl/eei_unit_dispatch.sv
// ---------------------------------------------------------------------------
// eei_unit_dispatch
// Routes EEI requests from the core to NUM_UNIT custom execution units over a
// per-unit req/ack handshake and returns the selected unit's registered
// response. Unmatched requests are answered locally (error = STRICT).
// Optional build macro: SOPHON_EEI_TIMEOUT_EN adds an 8-bit wait counter
// that abandons a unit after TIMEOUT cycles and answers with an error.
// Ports:
//   clk_i, rst_ni        clock, synchronous active-low reset
//   eei_req/ext/funct3/funct7/batch_len   core request
//   eei_ack/error/rd_op/rd_len/rd_val     registered core response
//   unit_req             one-hot request, held until the unit acks
//   unit_ack/error/rd_op/rd_len/rd_val    per-unit responses (unit i fields
//                        at [2i+:2], [5i+:5], [i*RD_MAX*32 +: RD_MAX*32])
//   busy                 dispatcher not idle
// ---------------------------------------------------------------------------
module eei_unit_dispatch
    import eei_pkg::*;
#(
    parameter int         NUM_UNIT      = 2,
    parameter int         RD_MAX        = 4,
    parameter int         F3_BASE       = 0,
    parameter logic [7:0] EXT_ONLY_MASK = 8'b0000_0010,
    parameter bit         STRICT        = 1'b1,
    parameter int         TIMEOUT       = 255
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic                                eei_req,
    input  logic                                eei_ext,
    input  logic [2:0]                          eei_funct3,
    input  logic [6:0]                          eei_funct7,
    input  logic [4:0]                          eei_batch_len,
    output logic                                eei_ack,
    output logic                                eei_error,
    output logic [1:0]                          eei_rd_op,
    output logic [4:0]                          eei_rd_len,
    output logic [RD_MAX*EEI_RD_W-1:0]          eei_rd_val,
    output logic [NUM_UNIT-1:0]                 unit_req,
    input  logic [NUM_UNIT-1:0]                 unit_ack,
    input  logic [NUM_UNIT-1:0]                 unit_error,
    input  logic [NUM_UNIT*2-1:0]               unit_rd_op,
    input  logic [NUM_UNIT*5-1:0]               unit_rd_len,
    input  logic [NUM_UNIT*RD_MAX*EEI_RD_W-1:0] unit_rd_val,
    output logic                                busy
);

    localparam int VW = RD_MAX * EEI_RD_W;

    if (NUM_UNIT < 1 || NUM_UNIT > 8 || F3_BASE < 0 || F3_BASE + NUM_UNIT > 8 ||
        RD_MAX < 1 || RD_MAX > 31 || TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_param
        $error("eei_unit_dispatch: illegal parameter combination");
    end

    eei_disp_state_e     state_r;
    eei_disp_state_e     state_nxt_s;
    eei_rsp_t            rsp_r;
    logic                dec_hit_s;
    logic [2:0]          dec_sel_s;
    logic [NUM_UNIT-1:0] dec_onehot_s;
    logic                start_s;
    logic                ack_sel_s;
    logic                err_sel_s;
    logic [1:0]          op_sel_s;
    logic [4:0]          len_sel_s;
    logic [VW-1:0]       val_sel_s;
    logic                unused_s;

`ifdef SOPHON_EEI_TIMEOUT_EN
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);
    logic [7:0] wait_cnt_r;
    logic       timeout_s;
    assign timeout_s = (wait_cnt_r == TO_LAST);
`endif

    // funct7 and batch_len belong to the unit protocol, not to routing.
    assign unused_s = ^{eei_funct7, eei_batch_len};

    eei_unit_decode #(
        .NUM_UNIT      (NUM_UNIT),
        .F3_BASE       (F3_BASE),
        .EXT_ONLY_MASK (EXT_ONLY_MASK)
    ) u_decode (
        .eei_funct3 (eei_funct3),
        .eei_ext    (eei_ext),
        .hit        (dec_hit_s),
        .sel        (dec_sel_s)
    );

    // While eei_ack is showing, the core still holds eei_req for that cycle;
    // that request has already been served and must not restart the FSM.
    assign start_s   = (state_r == IDLE) && eei_req && !eei_ack;
    assign ack_sel_s = |(unit_ack & unit_req);

    // The held one-hot unit_req doubles as the response mux select, so acks
    // and fields from non-selected units are masked off.
    always_comb begin
        dec_onehot_s = '0;
        err_sel_s    = 1'b0;
        op_sel_s     = 2'd0;
        len_sel_s    = 5'd0;
        val_sel_s    = '0;
        for (int i = 0; i < NUM_UNIT; i++) begin
            dec_onehot_s[i] = (dec_sel_s == 3'(i));
            err_sel_s = err_sel_s | (unit_error[i] & unit_req[i]);
            op_sel_s  = op_sel_s  | (unit_rd_op[2*i +: 2]  & {2{unit_req[i]}});
            len_sel_s = len_sel_s | (unit_rd_len[5*i +: 5] & {5{unit_req[i]}});
            val_sel_s = val_sel_s | (unit_rd_val[VW*i +: VW] & {VW{unit_req[i]}});
        end
    end

    // Next-state logic of the dispatcher FSM.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (start_s) begin
                    state_nxt_s = dec_hit_s ? WAIT : RESP;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            WAIT: begin
                if (ack_sel_s) begin
                    state_nxt_s = RESP;
`ifdef SOPHON_EEI_TIMEOUT_EN
                end else if (timeout_s) begin
                    state_nxt_s = RESP;
`endif
                end else begin
                    state_nxt_s = WAIT;
                end
            end
            RESP:    state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Unit handshake, response capture and the registered core response.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            unit_req   <= '0;
            rsp_r      <= '0;
            eei_rd_val <= '0;
            eei_ack    <= 1'b0;
            eei_error  <= 1'b0;
            eei_rd_op  <= RD_NONE;
            busy       <= 1'b0;
`ifdef SOPHON_EEI_TIMEOUT_EN
            wait_cnt_r <= 8'd0;
`endif
        end else begin
            eei_ack   <= 1'b0;
            eei_error <= 1'b0;
            eei_rd_op <= RD_NONE;
            busy      <= (state_nxt_s != IDLE);
            case (state_r)
                IDLE: begin
                    if (start_s && dec_hit_s) begin
                        unit_req <= dec_onehot_s;
`ifdef SOPHON_EEI_TIMEOUT_EN
                        wait_cnt_r <= 8'd0;
`endif
                    end else if (start_s) begin
                        rsp_r <= '{error: STRICT, rd_op: RD_NONE, rd_len: 5'd0};
                    end
                end
                WAIT: begin
                    if (ack_sel_s) begin
                        rsp_r <= '{error:  err_sel_s,
                                   rd_op:  op_sel_s,
                                   rd_len: eei_sanitize_len(op_sel_s, len_sel_s, 5'(RD_MAX))};
                        eei_rd_val <= val_sel_s;
                        unit_req   <= '0;
`ifdef SOPHON_EEI_TIMEOUT_EN
                    end else if (timeout_s) begin
                        rsp_r    <= '{error: 1'b1, rd_op: RD_NONE, rd_len: 5'd0};
                        unit_req <= '0;
                    end else begin
                        wait_cnt_r <= wait_cnt_r + 8'd1;
`endif
                    end
                end
                RESP: begin
                    eei_ack   <= 1'b1;
                    eei_error <= rsp_r.error;
                    eei_rd_op <= rsp_r.rd_op;
                end
                default: unit_req <= '0;
            endcase
        end
    end

    // The count is stored already sanitised and persists until the next capture.
    assign eei_rd_len = rsp_r.rd_len;

endmodule

// File: doc/eei_unit_dispatch.md
Name: eei_unit_dispatch

Overview:
- Parametrised successor to the single-level EEI response mux.
- Sits between the core's EEI port and NUM_UNIT custom execution units (fast GPIO, snapshot regs, future units).
- Decodes funct3 to select one unit and drives a per-unit req/ack handshake.
- Registers the selected unit's ack, error, rd_op, rd_len and rd_val back to the core through a small FSM.
- Adds an unmatched-opcode policy and busy tracking, which the flat mux lacks.

Parameters:
- NUM_UNIT, 2, number of attached custom units (1..8).
- RD_MAX, 4, number of 32-bit rd result words per response.
- F3_BASE, 0, funct3 served by unit 0; unit i serves F3_BASE+i (must satisfy F3_BASE+NUM_UNIT<=8).
- EXT_ONLY_MASK, 'b10, bit i set: unit i accepts only eei_ext=1 requests.
- STRICT, 1, 1: unmatched request is acked with eei_error=1; 0: acked with no error.
- TIMEOUT, 255, cycle limit for a unit ack (used only with the optional feature).

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset. Synchronous, active-low.
- eei_req  in  1  request; held high by the core until the eei_ack cycle.
- eei_ext  in  1  enhanced (batch) instruction.
- eei_funct3  in  3  unit select.
- eei_funct7  in  7  forwarded opcode.
- eei_batch_len  in  5  forwarded batch length.
- eei_ack  out  1  single-cycle response strobe.
- eei_error  out  1  error, valid with eei_ack.
- eei_rd_op  out  2  0 none, 1 single, 2 batch, 3 ext-batch.
- eei_rd_len  out  5  write-back count.
- eei_rd_val  out  RD_MAX*32  result words, flattened (word k at [32k+:32]).
- unit_req  out  NUM_UNIT  one-hot request, held until the matching unit_ack.
- unit_ack  in  NUM_UNIT  per-unit completion.
- unit_error  in  NUM_UNIT  per-unit error, valid with ack.
- unit_rd_op  in  NUM_UNIT*2  per-unit rd_op, valid with ack.
- unit_rd_len  in  NUM_UNIT*5  per-unit rd_len, valid with ack.
- unit_rd_val  in  NUM_UNIT*RD_MAX*32  per-unit results, valid with ack.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (rst_ni=0 at a clk_i edge):
  - state=IDLE.
  - All outputs 0: eei_ack, eei_error, eei_rd_op, eei_rd_len, eei_rd_val, unit_req, busy.
- A reset during WAIT abandons the transaction; no ack is issued.
- FSM states: IDLE, WAIT, RESP.
- IDLE, eei_req=1:
  - Decode hit when eei_funct3-F3_BASE < NUM_UNIT and (EXT_ONLY_MASK[i]==0 or eei_ext=1).
  - Hit: latch sel=i, assert unit_req[i] next cycle, go to WAIT.
  - Miss: go to RESP with eei_error=STRICT and rd_op=0.
- WAIT:
  - unit_req[sel] held.
  - On unit_ack[sel]=1: capture error, rd_op, rd_len and rd_val of unit sel; drop unit_req the next cycle; go to RESP.
  - Ack from a non-selected unit is ignored.
- RESP:
  - eei_ack=1 for exactly one cycle with the captured fields, then IDLE.
  - eei_rd_val and eei_rd_len hold their values until the next capture.
  - eei_rd_op returns to 0 in IDLE.
- Latency:
  - Hit: eei_ack is 2 cycles after the unit_ack edge, minimum 3 cycles from eei_req.
  - Miss: 2 cycles.
- eei_req deasserted in WAIT: request stays outstanding; the unit still completes. No cancel.
- unit_ack in the same cycle unit_req rises is accepted.
- Field sanitation in RESP: if captured rd_op==0, force eei_rd_len=0; clamp eei_rd_len to RD_MAX.

Optional Feature:
- Macro: SOPHON_EEI_TIMEOUT_EN.
- Defined:
  - 8-bit wait counter, cleared on WAIT entry.
  - On reaching TIMEOUT with no unit_ack: drop unit_req, go to RESP with eei_error=1, rd_op=0, rd_len=0.
  - A unit_ack arriving in the timeout cycle wins over the timeout.
- Undefined:
  - No counter; WAIT persists indefinitely.

Decomposition:
- Package eei_pkg holds:
  - state enum eei_disp_state_e.
  - rd_op constants RD_NONE, RD_SINGLE, RD_BATCH, RD_EXTBATCH.
  - typedef eei_rsp_t {error, rd_op, rd_len}.
  - constant EEI_RD_W=32.
- Sub-module eei_unit_decode: combinational funct3/ext to {hit, sel} decoder; parametrised identically.

Test Plan:
- Hit unit 0: funct3=0, ext=0, unit_ack[0] 4 cycles after unit_req with rd_op=1, rd_val[0]=0xDEADBEEF -> eei_ack 2 cycles later, rd_op=1, rd_val word0=0xDEADBEEF, error=0, busy low the cycle after ack.
- Ext-only gate: funct3=1, ext=0 with STRICT=1 -> no unit_req; eei_ack at cycle 2 with error=1. The same request with ext=1 -> unit_req[1] asserted.
- Unmatched funct3=5, NUM_UNIT=2, STRICT=0 -> eei_ack at cycle 2, error=0, rd_op=0, rd_len=0.
- Batch response rd_op=2, rd_len=7, RD_MAX=4 -> eei_rd_len=4. Response with rd_op=0, rd_len=3 -> eei_rd_len=0.
- Reset in WAIT: rst_ni low 1 cycle while unit_req[0]=1 -> all outputs 0 the next cycle, state IDLE, no eei_ack. A stray unit_ack afterwards is ignored.
- Timeout with SOPHON_EEI_TIMEOUT_EN defined, TIMEOUT=10, no unit_ack -> unit_req drops after 10 WAIT cycles, eei_ack with error=1. Same test without the macro -> still busy at 1000 cycles.
